// File: rtl/safety_core_obi_arb.sv
// Two-to-one OBI arbiter: round-robin instr/data onto one shared memory port,
// with an in-order ID FIFO that routes each response back to its requester.
module safety_core_obi_arb #(
  parameter int MaxTrans  = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   instr_req_i,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  output logic                   instr_gnt_o,
  output logic                   instr_rvalid_o,
  output logic [DataWidth-1:0]   instr_rdata_o,
  output logic                   instr_err_o,
  input  logic                   data_req_i,
  input  logic                   data_we_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic                   data_err_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic                   mem_err_i,
  output logic                   busy_o,
  output logic                   protocol_err_o
);

  localparam int BeWidth  = DataWidth / 8;
  localparam int CntWidth = $clog2(MaxTrans + 1);
  localparam int PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

  logic                rr_q, rr_d;
  logic                lock_q, lock_d;
  logic                lock_src_q, lock_src_d;
  logic [MaxTrans-1:0] fifo_q, fifo_d;
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                perr_q, perr_d;

  logic sel_src, sel_req, full, empty, fwd_req, push, pop, head_src;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(MaxTrans - 1)) begin
      ptr_inc = {PtrWidth{1'b0}};
    end else begin
      ptr_inc = p + PtrWidth'(1);
    end
  endfunction

  // A locked selection wins so a stalled address stays stable until granted.
  always_comb begin
    sel_src = 1'b0;
    if (lock_q) begin
      sel_src = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
      sel_src = ~rr_q;
    end else if (data_req_i) begin
      sel_src = 1'b1;
    end else begin
      sel_src = 1'b0;
    end
  end

  assign full     = (cnt_q == CntWidth'(MaxTrans));
  assign empty    = (cnt_q == {CntWidth{1'b0}});
  assign sel_req  = sel_src ? data_req_i : instr_req_i;
  assign fwd_req  = rst_ni & sel_req & ~full;
  assign push     = fwd_req & mem_gnt_i;
  assign pop      = rst_ni & mem_rvalid_i & ~empty;
  assign head_src = fifo_q[rd_ptr_q];

  assign mem_req_o   = fwd_req;
  assign mem_addr_o  = sel_src ? data_addr_i : instr_addr_i;
  assign mem_we_o    = sel_src & data_we_i;
  assign mem_be_o    = sel_src ? data_be_i : {BeWidth{1'b1}};
  assign mem_wdata_o = sel_src ? data_wdata_i : {DataWidth{1'b0}};

  assign instr_gnt_o    = push & ~sel_src;
  assign data_gnt_o     = push & sel_src;
  assign instr_rvalid_o = pop & ~head_src;
  assign data_rvalid_o  = pop & head_src;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;
  assign busy_o         = rst_ni & ~empty;
  assign protocol_err_o = rst_ni & perr_q;

  // Arbitration, lock and ID FIFO next state.
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    perr_d     = perr_q;
    if (push) begin
      rr_d             = sel_src;
      lock_d           = 1'b0;
      fifo_d[wr_ptr_q] = sel_src;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else if (fwd_req) begin
      lock_d     = 1'b1;
      lock_src_d = sel_src;
    end else begin
      lock_d = lock_q;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (mem_rvalid_i && empty) begin
      perr_d = 1'b1;
    end else begin
      perr_d = perr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= 1'b0;
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
      fifo_q     <= {MaxTrans{1'b0}};
      wr_ptr_q   <= {PtrWidth{1'b0}};
      rd_ptr_q   <= {PtrWidth{1'b0}};
      cnt_q      <= {CntWidth{1'b0}};
      perr_q     <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      perr_q     <= perr_d;
    end
  end

endmodule

// File: tb/tb_safety_core_obi_arb.sv
// Bench for safety_core_obi_arb: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_safety_core_obi_arb;
  localparam int MaxTrans = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0]  data_be_i, mem_be_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        busy_o, protocol_err_o;

  always #5 clk_i = ~clk_i;

  safety_core_obi_arb #(.MaxTrans(MaxTrans), .AddrWidth(32), .DataWidth(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [31:0] daddr;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_ig, e_dg, e_irv, e_drv, e_mreq;
    logic [31:0] e_maddr;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mkv(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                               input logic [31:0] daddr, input logic gnt, input logic rv,
                               input logic [31:0] rdata, input logic e_ig, input logic e_dg,
                               input logic e_irv, input logic e_drv, input logic e_mreq,
                               input logic [31:0] e_maddr, input logic e_busy);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv; v.e_drv = e_drv;
    v.e_mreq = e_mreq; v.e_maddr = e_maddr; v.e_busy = e_busy;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int q[$];
    int last, held, src, resp_src, tmp;
    bit perr_m, ip, dp, full, ereq, ehs;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dbe;
    logic        dwe;

    //                ireq iaddr      dreq daddr      gnt rv rdata        ig dg irv drv mreq maddr      busy
    vecs[0]  = mkv(1, 32'h1000, 0, 32'h0,    1, 0, 32'h0,        1, 0, 0, 0, 1, 32'h1000, 0);
    vecs[1]  = mkv(0, 32'h0,    0, 32'h0,    0, 1, 32'hDEADBEEF, 0, 0, 1, 0, 0, 32'h0,    1);
    vecs[2]  = mkv(0, 32'h0,    0, 32'h0,    0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,    0);
    vecs[3]  = mkv(1, 32'h2000, 1, 32'h3000, 1, 0, 32'h0,        0, 1, 0, 0, 1, 32'h3000, 0);
    vecs[4]  = mkv(1, 32'h2000, 1, 32'h3000, 1, 1, 32'hA1,       1, 0, 0, 1, 1, 32'h2000, 1);
    vecs[5]  = mkv(1, 32'h2000, 1, 32'h3000, 1, 1, 32'hA2,       0, 1, 1, 0, 1, 32'h3000, 1);
    vecs[6]  = mkv(1, 32'h2000, 1, 32'h3000, 1, 1, 32'hA3,       1, 0, 0, 1, 1, 32'h2000, 1);
    vecs[7]  = mkv(0, 32'h0,    0, 32'h0,    0, 1, 32'hA4,       0, 0, 1, 0, 0, 32'h0,    1);
    vecs[8]  = mkv(0, 32'h0,    1, 32'h3100, 1, 0, 32'h0,        0, 1, 0, 0, 1, 32'h3100, 0);
    vecs[9]  = mkv(0, 32'h0,    0, 32'h0,    0, 1, 32'hB1,       0, 0, 0, 1, 0, 32'h0,    1);
    vecs[10] = mkv(0, 32'h0,    0, 32'h0,    0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,    0);
    vecs[11] = mkv(0, 32'h0,    1, 32'h4000, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h4000, 0);
    vecs[12] = mkv(1, 32'h5000, 1, 32'h4000, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h4000, 0);
    vecs[13] = mkv(1, 32'h5000, 1, 32'h4000, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h4000, 0);
    vecs[14] = mkv(1, 32'h5000, 1, 32'h4000, 1, 0, 32'h0,        0, 1, 0, 0, 1, 32'h4000, 0);
    vecs[15] = mkv(1, 32'h5000, 0, 32'h0,    1, 0, 32'h0,        1, 0, 0, 0, 1, 32'h5000, 1);
    vecs[16] = mkv(0, 32'h0,    0, 32'h0,    0, 1, 32'hC1,       0, 0, 0, 1, 0, 32'h0,    1);
    vecs[17] = mkv(0, 32'h0,    0, 32'h0,    0, 1, 32'hC2,       0, 0, 1, 0, 0, 32'h0,    1);
    vecs[18] = mkv(0, 32'h0,    0, 32'h0,    0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,    0);

    // Reset state
    rst_ni = 1'b0;
    idle();
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    #1;
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk1("rst_igrant", instr_gnt_o, 1'b0);
    chk1("rst_dgrant", data_gnt_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    idle();
    #1;
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_perr", protocol_err_o, 1'b0);

    // Directed table: single read, contention, lock
    for (int i = 0; i < 19; i++) begin
      instr_req_i = vecs[i].ireq; instr_addr_i = vecs[i].iaddr;
      data_req_i = vecs[i].dreq; data_addr_i = vecs[i].daddr;
      data_we_i = 1'b1; data_be_i = 4'h5; data_wdata_i = 32'h1234_5678;
      mem_gnt_i = vecs[i].gnt; mem_rvalid_i = vecs[i].rv; mem_rdata_i = vecs[i].rdata;
      mem_err_i = 1'b0;
      #1;
      chk1($sformatf("vec%0d_igrant", i), instr_gnt_o, vecs[i].e_ig);
      chk1($sformatf("vec%0d_dgrant", i), data_gnt_o, vecs[i].e_dg);
      chk1($sformatf("vec%0d_irvalid", i), instr_rvalid_o, vecs[i].e_irv);
      chk1($sformatf("vec%0d_drvalid", i), data_rvalid_o, vecs[i].e_drv);
      chk1($sformatf("vec%0d_mem_req", i), mem_req_o, vecs[i].e_mreq);
      chk1($sformatf("vec%0d_busy", i), busy_o, vecs[i].e_busy);
      chk1($sformatf("vec%0d_perr", i), protocol_err_o, 1'b0);
      if (vecs[i].e_mreq)
        chk32($sformatf("vec%0d_mem_addr", i), mem_addr_o, vecs[i].e_maddr);
      if (vecs[i].e_irv)
        chk32($sformatf("vec%0d_irdata", i), instr_rdata_o, vecs[i].rdata);
      if (vecs[i].e_drv)
        chk32($sformatf("vec%0d_drdata", i), data_rdata_o, vecs[i].rdata);
      tick();
    end
    idle();

    // Full: two outstanding instr transactions block a third
    instr_req_i = 1'b1; instr_addr_i = 32'h6000; mem_gnt_i = 1'b1;
    #1 chk1("full_g0", instr_gnt_o, 1'b1);
    tick();
    instr_addr_i = 32'h6004;
    #1 chk1("full_g1", instr_gnt_o, 1'b1);
    tick();
    instr_addr_i = 32'h6008;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk1("full_mem_req", mem_req_o, 1'b0);
      chk1("full_igrant", instr_gnt_o, 1'b0);
      chk1("full_busy", busy_o, 1'b1);
      tick();
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0F01;
    #1;
    chk1("full_pop_mem_req", mem_req_o, 1'b0);
    chk1("full_pop_igrant", instr_gnt_o, 1'b0);
    chk1("full_pop_irvalid", instr_rvalid_o, 1'b1);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    chk1("full_g2", instr_gnt_o, 1'b1);
    chk32("full_g2_addr", mem_addr_o, 32'h6008);
    tick();
    instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1 chk1("full_drain_irvalid", instr_rvalid_o, 1'b1);
      tick();
    end
    mem_rvalid_i = 1'b0;
    #1 chk1("full_drain_busy", busy_o, 1'b0);

    // Stray response with the FIFO empty
    mem_rvalid_i = 1'b1;
    #1;
    chk1("stray_irvalid", instr_rvalid_o, 1'b0);
    chk1("stray_drvalid", data_rvalid_o, 1'b0);
    chk1("stray_perr_same", protocol_err_o, 1'b0);
    tick();
    mem_rvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk1("stray_perr_sticky", protocol_err_o, 1'b1);
      tick();
    end
    rst_ni = 1'b0;
    #1 chk1("stray_perr_in_rst", protocol_err_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    #1 chk1("stray_perr_cleared", protocol_err_o, 1'b0);

    // Reset with one transaction outstanding
    data_req_i = 1'b1; data_addr_i = 32'h7000; mem_gnt_i = 1'b1;
    #1 chk1("midrst_dgrant", data_gnt_o, 1'b1);
    tick();
    rst_ni = 1'b0; instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    #1;
    chk1("midrst_igrant", instr_gnt_o, 1'b0);
    chk1("midrst_dgrant_rst", data_gnt_o, 1'b0);
    chk1("midrst_irvalid", instr_rvalid_o, 1'b0);
    chk1("midrst_drvalid", data_rvalid_o, 1'b0);
    chk1("midrst_mem_req", mem_req_o, 1'b0);
    chk1("midrst_busy", busy_o, 1'b0);
    chk1("midrst_perr", protocol_err_o, 1'b0);
    tick();
    rst_ni = 1'b1;
    idle();
    #1;
    chk1("midrst_busy_after", busy_o, 1'b0);
    chk1("midrst_perr_after", protocol_err_o, 1'b0);
    tick();
    mem_rvalid_i = 1'b1;
    #1;
    chk1("late_drvalid", data_rvalid_o, 1'b0);
    chk1("late_irvalid", instr_rvalid_o, 1'b0);
    tick();
    mem_rvalid_i = 1'b0;
    #1 chk1("late_perr", protocol_err_o, 1'b1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;

    // Random traffic against the reference model
    last = 0; held = -1; perr_m = 1'b0; ip = 1'b0; dp = 1'b0;
    ia = 32'h0; da = 32'h0; dwd = 32'h0; dbe = 4'h0; dwe = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1'b1; ia = $urandom;
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1'b1; da = $urandom; dwe = 1'($urandom_range(0, 1));
        dbe = 4'($urandom); dwd = $urandom;
      end
      instr_req_i = ip; instr_addr_i = ia;
      data_req_i = dp; data_addr_i = da; data_we_i = dwe; data_be_i = dbe; data_wdata_i = dwd;
      mem_gnt_i = ($urandom_range(0, 3) != 0);
      if (q.size() > 0) mem_rvalid_i = ($urandom_range(0, 2) != 0);
      else mem_rvalid_i = ($urandom_range(0, 60) == 0);
      mem_rdata_i = $urandom; mem_err_i = 1'($urandom_range(0, 1));

      full = (q.size() == MaxTrans);
      if (held >= 0) src = held;
      else if (ip && dp) src = 1 - last;
      else if (dp) src = 1;
      else src = 0;
      ereq = ((src == 1) ? dp : ip) && !full;
      ehs  = ereq && mem_gnt_i;
      resp_src = (mem_rvalid_i && q.size() > 0) ? q[0] : -1;

      #1;
      chk1("rnd_mem_req", mem_req_o, ereq);
      chk1("rnd_igrant", instr_gnt_o, ehs && src == 0);
      chk1("rnd_dgrant", data_gnt_o, ehs && src == 1);
      chk1("rnd_irvalid", instr_rvalid_o, resp_src == 0);
      chk1("rnd_drvalid", data_rvalid_o, resp_src == 1);
      chk1("rnd_busy", busy_o, q.size() != 0);
      chk1("rnd_perr", protocol_err_o, perr_m);
      if (ereq) begin
        chk32("rnd_mem_addr", mem_addr_o, (src == 1) ? da : ia);
        chk1("rnd_mem_we", mem_we_o, (src == 1) ? dwe : 1'b0);
        chk32("rnd_mem_be", 32'(mem_be_o), (src == 1) ? 32'(dbe) : 32'hF);
        chk32("rnd_mem_wdata", mem_wdata_o, (src == 1) ? dwd : 32'h0);
      end
      if (resp_src == 0) begin
        chk32("rnd_irdata", instr_rdata_o, mem_rdata_i);
        chk1("rnd_ierr", instr_err_o, mem_err_i);
      end
      if (resp_src == 1) begin
        chk32("rnd_drdata", data_rdata_o, mem_rdata_i);
        chk1("rnd_derr", data_err_o, mem_err_i);
      end

      if (mem_rvalid_i) begin
        if (q.size() > 0) tmp = q.pop_front();
        else perr_m = 1'b1;
      end
      if (ehs) begin
        q.push_back(src);
        last = src;
        held = -1;
        if (src == 1) dp = 1'b0;
        else ip = 1'b0;
      end else if (ereq) begin
        held = src;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
